imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into instruction memory at consecutive word addresses starting at 0. It holds the CPU in reset until the whole program has been committed.

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a byte stream (LEN_LO, LEN_HI, 4*N data bytes) and writes little-endian
// 32-bit words to consecutive word addresses. The CPU stays in reset until done.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // State entered once the data phase is over (or skipped for N == 0).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;

  // Running checksum: plain XOR fold of every data byte.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  localparam state_t S_TAIL = S_FLUSH;
`endif

  state_t      state_r;
  state_t      next_state_s;
  logic        in_ready_s;
  logic        xfer_s;
  logic [15:0] len_s;
  logic        last_word_s;
  logic [7:0]  len_lo_r;
  logic [15:0] len_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] asm_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [15:0] words_r;
  logic        done_r;
  logic        error_r;
  logic        cpu_reset_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;
`endif

  assign len_s       = {in_data, len_lo_r};
  assign last_word_s = ((words_r + 16'd1) == len_r);
  assign xfer_s      = in_valid && in_ready_s;

  assign in_ready     = in_ready_s;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign cpu_reset    = cpu_reset_r;
  assign done         = done_r;
  assign error        = error_r;
  assign words_loaded = words_r;

  // Accept bytes only in stream-consuming states and never while reset is held.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      S_LEN_LO, S_LEN_HI, S_DATA: in_ready_s = !reset;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                     in_ready_s = !reset;
`endif
      default:                    in_ready_s = 1'b0;
    endcase
  end

  // Next-state decode for the stream parser.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_LEN_LO: begin
        if (xfer_s) next_state_s = S_LEN_HI;
        else        next_state_s = state_r;
      end
      S_LEN_HI: begin
        if (!xfer_s)                         next_state_s = state_r;
        else if ({1'b0, len_s} > DEPTH_LIM)  next_state_s = S_ERROR;
        else if (len_s == 16'd0)             next_state_s = S_TAIL;
        else                                 next_state_s = S_DATA;
      end
      S_DATA: begin
        if (xfer_s && (byte_cnt_r == 2'd3) && last_word_s) next_state_s = S_TAIL;
        else                                                next_state_s = state_r;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (!xfer_s)                      next_state_s = state_r;
        else if (in_data == csum_r)       next_state_s = S_FLUSH;
        else                              next_state_s = S_ERROR;
      end
`endif
      S_FLUSH: next_state_s = S_DONE;
      S_DONE:  next_state_s = S_DONE;
      S_ERROR: next_state_s = S_ERROR;
      default: next_state_s = S_ERROR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_LEN_LO;
    else       state_r <= next_state_s;
  end

  // Length capture, word assembly, memory write strobe and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo_r    <= 8'd0;
      len_r       <= 16'd0;
      byte_cnt_r  <= 2'd0;
      asm_r       <= 24'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      words_r     <= 16'd0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      mem_we_r    <= 1'b0;
      done_r      <= (next_state_s == S_DONE);
      error_r     <= (next_state_s == S_ERROR);
      cpu_reset_r <= (next_state_s != S_DONE);
      if (xfer_s) begin
        case (state_r)
          S_LEN_LO: len_lo_r <= in_data;
          S_LEN_HI: len_r    <= len_s;
          S_DATA: begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r     <= csum_fold(csum_r, in_data);
`endif
            case (byte_cnt_r)
              2'd0: asm_r[7:0]   <= in_data;
              2'd1: asm_r[15:8]  <= in_data;
              2'd2: asm_r[23:16] <= in_data;
              2'd3: begin
                // Fourth byte completes the word: write it at the current index.
                mem_wdata_r <= {in_data, asm_r};
                mem_addr_r  <= {14'd0, words_r, 2'b00};
                mem_we_r    <= 1'b1;
                words_r     <= words_r + 16'd1;
              end
              default: asm_r <= asm_r;
            endcase
          end
          default: len_lo_r <= len_lo_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes
// plus per-scenario tasks checking handshake, status flags and reset behaviour.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];
  logic [63:0] mon_e;
  logic [15:0] mon_w;

  logic [7:0] prog [10] = '{8'h02, 8'h00, 8'hB3, 8'h03, 8'h53, 8'h00, 8'h33, 8'h85, 8'h84, 8'h40};

  imem_loader #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected addr=%h data=%h required=no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e[63:32] || mem_wdata !== mon_e[31:0]) begin
          failures++;
          $display("FAIL write_value addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_e[63:32], mon_e[31:0]);
        end
        mon_w = 16'((mon_e[63:32] >> 2) + 32'd1);
        checks++;
        if (words_loaded !== mon_w) begin
          failures++;
          $display("FAIL words_with_we got=%0d required=%0d", words_loaded, mon_w);
        end
      end
    end
  end

  task automatic set_prog(input bit with_csum, input logic [7:0] cs);
    stim.delete();
    foreach (prog[i]) stim.push_back(prog[i]);
    if (with_csum) stim.push_back(cs);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Offer one byte, wait (bounded) for acceptance, then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit gap_ready);
    bit ok = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout byte=%h in_ready=%b required=1", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (gap_ready) begin
          checks++;
          if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_in_gap got=%b required=1", in_ready);
          end
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Send stim, pushing expected writes; then check the terminal state.
  task automatic run_stream(input int gap, input bit exp_err);
    int n;
    int last;
    bit last_is_data;
    n = int'({stim[1], stim[0]});
    last = stim.size() - 1;
    last_is_data = (n > 0) && (last == 1 + 4 * n);
    for (int i = 0; i <= last; i++) begin
      if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
        exp_q.push_back({32'(4 * ((i - 2) / 4)), stim[i], stim[i-1], stim[i-2], stim[i-3]});
      send_byte(stim[i], (i == last) ? 0 : gap, 1'b1);
    end
    @(negedge clk);
    if (exp_err) begin
      checks++;
      if ({error, cpu_reset, in_ready, done} !== 4'b1100) begin
        failures++;
        $display("FAIL error_state err=%b cpu_reset=%b ready=%b done=%b required=1 1 0 0",
                 error, cpu_reset, in_ready, done);
      end
    end else begin
      checks++;
      if ({done, in_ready, cpu_reset} !== 3'b001) begin
        failures++;
        $display("FAIL flush_cycle done=%b ready=%b cpu_reset=%b required=0 0 1", done, in_ready, cpu_reset);
      end
      if (last_is_data) begin
        checks++;
        if (mem_we !== 1'b1) begin
          failures++;
          $display("FAIL final_we got=%b required=1", mem_we);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if ({done, cpu_reset, error} !== 3'b100 || words_loaded !== 16'(n)) begin
        failures++;
        $display("FAIL done_state done=%b cpu_reset=%b err=%b words=%0d required=1 0 0 %0d",
                 done, cpu_reset, error, words_loaded, n);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL writes_missing pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, words_loaded} !==
        {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_values ready=%b we=%b addr=%h wdata=%h cpu_reset=%b done=%b err=%b words=%0d",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, words_loaded);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
`ifdef IMEM_LOADER_CHECKSUM_EN
    set_prog(1'b1, 8'h91);
`else
    set_prog(1'b0, 8'h00);
`endif
    run_stream(0, 1'b0);
  endtask

  task automatic test_ignore_after_done();
    int w0;
    w0 = wr_count;
    in_data = 8'hFF;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || done !== 1'b1) begin
        failures++;
        $display("FAIL done_ignores ready=%b done=%b required=0 1", in_ready, done);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (wr_count != w0 || words_loaded !== 16'd2) begin
      failures++;
      $display("FAIL done_no_write writes=%0d words=%0d required=%0d 2", wr_count - w0, words_loaded, 0);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
    set_prog(1'b1, 8'h91);
`else
    set_prog(1'b0, 8'h00);
`endif
    run_stream(3, 1'b0);
  endtask

  task automatic test_len_overflow();
    int w0;
    apply_reset();
    w0 = wr_count;
    stim.delete();
    stim.push_back(8'h41);
    stim.push_back(8'h00);
    run_stream(0, 1'b1);
    in_valid = 1'b1;
    in_data = 8'h12;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || error !== 1'b1 || cpu_reset !== 1'b1) begin
        failures++;
        $display("FAIL error_sticky ready=%b err=%b cpu_reset=%b required=0 1 1", in_ready, error, cpu_reset);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (wr_count != w0) begin
      failures++;
      $display("FAIL overflow_no_write writes=%0d required=0", wr_count - w0);
    end
  endtask

  task automatic test_zero_len();
    int w0;
    apply_reset();
    w0 = wr_count;
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    run_stream(0, 1'b0);
    checks++;
    if (wr_count != w0) begin
      failures++;
      $display("FAIL zero_len_no_write writes=%0d required=0", wr_count - w0);
    end
  endtask

  task automatic test_mid_reset();
    int w0;
    apply_reset();
    w0 = wr_count;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) exp_q.push_back({32'd0, prog[5], prog[4], prog[3], prog[2]});
      send_byte(prog[i], 0, 1'b1);
    end
    @(negedge clk);
    checks++;
    if (wr_count != w0 + 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_first_write writes=%0d required=1", wr_count - w0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, words_loaded} !==
        {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL mid_reset_values ready=%b we=%b addr=%h wdata=%h cpu_reset=%b done=%b err=%b words=%0d",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, words_loaded);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready_after got=%b required=1", in_ready);
    end
    test_basic();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int w0;
    apply_reset();
    set_prog(1'b1, 8'h91);
    run_stream(0, 1'b0);
    apply_reset();
    w0 = wr_count;
    set_prog(1'b1, 8'h90);
    run_stream(0, 1'b1);
    checks++;
    if (wr_count != w0 + 2) begin
      failures++;
      $display("FAIL csum_bad_writes writes=%0d required=2", wr_count - w0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_after_done();
    test_gaps();
    test_len_overflow();
    test_zero_len();
    test_mid_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
